mips_mc_controller: RTL



---
 rtl/mips_ctrl_pkg.sv | 74 +++++++
 rtl/mips_ctrl_decoder.sv | 41 ++++
 rtl/mips_mc_controller.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared encodings for the multi-cycle MIPS control sequencer
// Holds the sequencer state enum, the instruction-class enum, opCode/func
// constants and the mux-select encodings driven toward the datapath.
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_e;

  typedef enum logic [3:0] {
    CLS_NONE = 4'd0,
    CLS_ADD  = 4'd1,
    CLS_SUB  = 4'd2,
    CLS_AND  = 4'd3,
    CLS_OR   = 4'd4,
    CLS_JR   = 4'd5,
    CLS_LW   = 4'd6,
    CLS_SW   = 4'd7,
    CLS_BEQ  = 4'd8,
    CLS_ADDI = 4'd9,
    CLS_J    = 4'd10,
    CLS_JAL  = 4'd11
  } class_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;

  localparam logic [1:0] REGSRC_PC  = 2'd0;
  localparam logic [1:0] REGSRC_MEM = 2'd1;
  localparam logic [1:0] REGSRC_ALU = 2'd2;

  localparam logic [1:0] REGDST_RT  = 2'd0;
  localparam logic [1:0] REGDST_RD  = 2'd1;
  localparam logic [1:0] REGDST_R31 = 2'd2;

  localparam logic [1:0] PCSRC_PC4    = 2'd0;
  localparam logic [1:0] PCSRC_BRANCH = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_RS     = 2'd3;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;
  localparam logic [1:0] ALU_OR  = 2'd3;

  // {ALUSrc, ALUOp} for a class. Jumps do not use the ALU and get ADD/rt.
  function automatic logic [2:0] alu_ctrl(input class_e c);
    case (c)
      CLS_SUB, CLS_BEQ:         alu_ctrl = {1'b0, ALU_SUB};
      CLS_AND:                  alu_ctrl = {1'b0, ALU_AND};
      CLS_OR:                   alu_ctrl = {1'b0, ALU_OR};
      CLS_LW, CLS_SW, CLS_ADDI: alu_ctrl = {1'b1, ALU_ADD};
      default:                  alu_ctrl = {1'b0, ALU_ADD};
    endcase
  endfunction

endpackage

// File: rtl/mips_ctrl_decoder.sv
// rtl/mips_ctrl_decoder.sv - combinational opCode/func to instruction-class decoder
// Ports:
//   opcode_i  [5:0]  IR[31:26]
//   func_i    [5:0]  IR[5:0], only meaningful for R-type
//   cls_o     class  decoded instruction class (CLS_NONE when unsupported)
//   illegal_o        unsupported opCode or R-type func
module mips_ctrl_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] func_i,
  output class_e     cls_o,
  output logic       illegal_o
);

  always_comb begin
    cls_o = CLS_NONE;
    case (opcode_i)
      OP_RTYPE: begin
        case (func_i)
          FN_ADD:  cls_o = CLS_ADD;
          FN_SUB:  cls_o = CLS_SUB;
          FN_AND:  cls_o = CLS_AND;
          FN_OR:   cls_o = CLS_OR;
          FN_JR:   cls_o = CLS_JR;
          default: cls_o = CLS_NONE;
        endcase
      end
      OP_LW:   cls_o = CLS_LW;
      OP_SW:   cls_o = CLS_SW;
      OP_BEQ:  cls_o = CLS_BEQ;
      OP_ADDI: cls_o = CLS_ADDI;
      OP_J:    cls_o = CLS_J;
      OP_JAL:  cls_o = CLS_JAL;
      default: cls_o = CLS_NONE;
    endcase
  end

  assign illegal_o = (cls_o == CLS_NONE);

endmodule

// File: rtl/mips_mc_controller.sv
// rtl/mips_mc_controller.sv - multi-cycle MIPS control sequencer (FETCH/DECODE/EXEC/MEM/WB)
// Optional feature macro: MIPS_CTRL_PERF_CNT_EN adds cycleCount/instRet counters.
// Ports:
//   clk, rst          rising-edge clock, async active-high reset
//   opCode, func      IR fields from the datapath
//   zero              ALU zero flag (beq decision)
//   memReady          shared memory port completed the access this cycle
//   memReq, memWrite  memory request / data write enable
//   pcWrite, irWrite  PC and IR load strobes
//   regSrc, regDst    register write-back source and address selects
//   pcSrc             next-PC select
//   ALUSrc, ALUOp     ALU operand-B select and operation
//   regWrite          register file write enable
//   illegal           sticky trap indicator
//   cycleCount, instRet (MIPS_CTRL_PERF_CNT_EN only) free-running counters
module mips_mc_controller
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opCode,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       memReady,
  output logic       memReq,
  output logic       pcWrite,
  output logic       irWrite,
  output logic [1:0] regSrc,
  output logic [1:0] regDst,
  output logic [1:0] pcSrc,
  output logic       ALUSrc,
  output logic [1:0] ALUOp,
  output logic       regWrite,
  output logic       memWrite,
  output logic       illegal
`ifdef MIPS_CTRL_PERF_CNT_EN
  ,
  output logic [31:0] cycleCount,
  output logic [31:0] instRet
`endif
);

  state_e state_q, state_d;
  class_e cls_q, cls_d;
  class_e dec_cls;
  logic   dec_illegal;

  mips_ctrl_decoder u_decoder (
    .opcode_i  (opCode),
    .func_i    (func),
    .cls_o     (dec_cls),
    .illegal_o (dec_illegal)
  );

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    case (state_q)
      ST_RST:   state_d = ST_FETCH;
      ST_FETCH: if (memReady) state_d = ST_DECODE;
      ST_DECODE: begin
        // Class is captured here so EXEC/MEM/WB never depend on IR again.
        cls_d   = dec_cls;
        state_d = dec_illegal ? ST_TRAP : ST_EXEC;
      end
      ST_EXEC: begin
        case (cls_q)
          CLS_LW, CLS_SW:                               state_d = ST_MEM;
          CLS_ADD, CLS_SUB, CLS_AND, CLS_OR, CLS_ADDI:  state_d = ST_WB;
          default:                                      state_d = ST_FETCH;
        endcase
      end
      ST_MEM:   if (memReady) state_d = (cls_q == CLS_SW) ? ST_FETCH : ST_WB;
      ST_WB:    state_d = ST_FETCH;
      ST_TRAP:  state_d = ST_TRAP;
      default:  state_d = ST_RST;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RST;
      cls_q   <= CLS_NONE;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
    end
  end

  // Outputs decode the registered state/class; memReady and zero only reach
  // irWrite (FETCH exit) and pcWrite (beq EXEC).
  always_comb begin
    memReq   = 1'b0;
    pcWrite  = 1'b0;
    irWrite  = 1'b0;
    regSrc   = REGSRC_PC;
    regDst   = REGDST_RT;
    pcSrc    = PCSRC_PC4;
    ALUSrc   = 1'b0;
    ALUOp    = ALU_ADD;
    regWrite = 1'b0;
    memWrite = 1'b0;
    illegal  = 1'b0;
    case (state_q)
      ST_FETCH: begin
        memReq  = 1'b1;
        irWrite = memReady;
      end
      ST_DECODE: begin
        pcWrite = 1'b1;
        pcSrc   = PCSRC_PC4;
      end
      ST_EXEC: begin
        {ALUSrc, ALUOp} = alu_ctrl(cls_q);
        case (cls_q)
          CLS_BEQ: begin
            pcSrc   = PCSRC_BRANCH;
            pcWrite = zero;
          end
          CLS_J: begin
            pcSrc   = PCSRC_JUMP;
            pcWrite = 1'b1;
          end
          CLS_JAL: begin
            // PC was already incremented in DECODE, so the link value is PC.
            pcSrc    = PCSRC_JUMP;
            pcWrite  = 1'b1;
            regWrite = 1'b1;
            regDst   = REGDST_R31;
            regSrc   = REGSRC_PC;
          end
          CLS_JR: begin
            pcSrc   = PCSRC_RS;
            pcWrite = 1'b1;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        // ALU controls held: the address is computed combinationally.
        {ALUSrc, ALUOp} = alu_ctrl(cls_q);
        memReq   = 1'b1;
        memWrite = (cls_q == CLS_SW);
      end
      ST_WB: begin
        {ALUSrc, ALUOp} = alu_ctrl(cls_q);
        regWrite = 1'b1;
        case (cls_q)
          CLS_LW: begin
            regSrc = REGSRC_MEM;
            regDst = REGDST_RT;
          end
          CLS_ADDI: begin
            regSrc = REGSRC_ALU;
            regDst = REGDST_RT;
          end
          default: begin
            regSrc = REGSRC_ALU;
            regDst = REGDST_RD;
          end
        endcase
      end
      ST_TRAP: illegal = 1'b1;
      default: ;
    endcase
  end

`ifdef MIPS_CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] inst_ret_q, inst_ret_d;
  logic        retire;

  // Last cycle of an instruction: jump/branch EXEC, sw MEM completion, any WB.
  always_comb begin
    retire = 1'b0;
    case (state_q)
      ST_EXEC: retire = (cls_q == CLS_BEQ) || (cls_q == CLS_J) ||
                        (cls_q == CLS_JAL) || (cls_q == CLS_JR);
      ST_MEM:  retire = (cls_q == CLS_SW) && memReady;
      ST_WB:   retire = 1'b1;
      default: retire = 1'b0;
    endcase
  end

  assign cycle_cnt_d = (state_q != ST_RST) ? cycle_cnt_q + 32'd1 : cycle_cnt_q;
  assign inst_ret_d  = retire ? inst_ret_q + 32'd1 : inst_ret_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt_q <= 32'd0;
      inst_ret_q  <= 32'd0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      inst_ret_q  <= inst_ret_d;
    end
  end

  assign cycleCount = cycle_cnt_q;
  assign instRet    = inst_ret_q;
`endif

endmodule
